serial_deserializer: RTL

- Upstream stage of the byte queue in TOP: collects bits strobed in on data_in/write_in and assembles them into a WIDTH-bit word.
- Pushes each completed word into the queue with a one-cycle enqueue pulse.
- Back-pressures the serial source through status_out while a word is waiting for queue space.

---
 rtl/serial_deserializer.sv | 83 ++++++++
 1 files changed

// File: rtl/serial_deserializer.sv
// Serial-to-parallel front end for the byte queue: assembles WIDTH strobed bits
// into a word, then holds it (back-pressuring the source) until the queue takes it.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clock_1MHz,
    input  logic                         rst,
    input  logic                         data_in,
    input  logic                         write_in,
    input  logic                         queue_full_in,
    output logic                         status_out,
    output logic                         enqueue_out,
    output logic [WIDTH-1:0]             data_out,
    output logic                         overrun_out,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {ACCEPT = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_reg;
    logic             accept_bit;
    logic             word_done;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    assign accept_bit = (state == ACCEPT) && write_in;
    assign word_done  = accept_bit && (bit_count_out == LAST_BIT);

    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst)
            state <= ACCEPT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCEPT: if (word_done) state_next = HOLD;
            HOLD:   if (!queue_full_in) state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

    always_comb begin
        status_out = (state == ACCEPT);
    end

    // Datapath: shift/count in ACCEPT, word capture on the last bit, push pulse out of HOLD.
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            shift_reg     <= '0;
            bit_count_out <= '0;
            data_out      <= '0;
            enqueue_out   <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            enqueue_out <= (state == HOLD) && !queue_full_in;
            if ((state == HOLD) && write_in)
                overrun_out <= 1'b1;
            if (accept_bit) begin
                shift_reg <= shift_in(shift_reg, data_in);
                if (word_done) begin
                    data_out      <= shift_in(shift_reg, data_in);
                    bit_count_out <= '0;
                end else begin
                    bit_count_out <= bit_count_out + 1'b1;
                end
            end
        end
    end

endmodule
